// File: rtl/mix_weight_ctrl.sv
// mix_weight_ctrl
//   Sequencer and access arbiter for the mix-layer weight RAM during training.
//   When idle it hands the RAM read port to the forward pass. A train request
//   runs the transpose engine over the weights, then the optimizer update
//   engine, and finishes with a one-cycle done pulse. RAM addresses and the
//   write enable come from whichever engine currently owns the RAM.
//
//   Optional feature macro: MIX_WEIGHT_CTRL_WATCHDOG_EN
//     Defined   : per-phase watchdog (TIMEOUT cycles) on TRANS and OPT. On
//                 expiry it sets a sticky err and returns to IDLE without done.
//     Undefined : no watchdog, err is tied to 0.
//
//   Handshake: the run outputs are levels. An engine reports completion with a
//   one-cycle valid while its run is high. A valid seen outside the owning phase
//   is ignored. Dropping run resets the engine.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     train_start           one-cycle train-sequence request
//     fwd_req / fwd_gnt     forward-pass read-port request (level) / grant
//     fwd_raddr             forward read address
//     trans_run/valid/raddr transpose engine run, finish, read address
//     opt_run/valid         optimizer run, finish
//     opt_raddr/waddr/we    optimizer read address, write address, write enable
//     w_raddr/w_waddr/w_we  weight RAM read address, write address, write enable
//     busy                  train sequence in progress (TRANS, OPT)
//     done                  one-cycle completion pulse
//     err                   sticky watchdog error
//
//   The FSM state is kept in state_q so that checkers can bind to it.
module mix_weight_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  train_start,
  input  logic                  fwd_req,
  output logic                  fwd_gnt,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr,
  output logic                  trans_run,
  input  logic                  trans_valid,
  input  logic [ADDR_WIDTH-1:0] trans_raddr,
  output logic                  opt_run,
  input  logic                  opt_valid,
  input  logic [ADDR_WIDTH-1:0] opt_raddr,
  input  logic [ADDR_WIDTH-1:0] opt_waddr,
  input  logic                  opt_we,
  output logic [ADDR_WIDTH-1:0] w_raddr,
  output logic [ADDR_WIDTH-1:0] w_waddr,
  output logic                  w_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_TRANS = 3'd2,
    S_OPT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   wd_expire;
  logic   enter_trans;

  assign enter_trans = (state_d == S_TRANS) && (state_q != S_TRANS);

  // State register. Asynchronous reset returns to IDLE, so every Moore output
  // (run levels included) drops as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      S_IDLE: begin
        // A train request wins over a simultaneous forward request.
        if (train_start)  state_d = S_TRANS;
        else if (fwd_req) state_d = S_FWD;
      end
      S_FWD: begin
        // The forward pass is never preempted; a train request is remembered
        // and taken as soon as the read port is released.
        if (train_start) pending_d = 1'b1;
        if (!fwd_req)    state_d = (pending_q || train_start) ? S_TRANS : S_IDLE;
      end
      S_TRANS: begin
        if (trans_valid)    state_d = S_OPT;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_OPT: begin
        if (opt_valid)      state_d = S_DONE;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_trans) pending_d = 1'b0;
  end

  // Output decode: Moore flags plus combinational address muxes, so the RAM
  // path sees no added latency.
  always_comb begin
    fwd_gnt   = 1'b0;
    trans_run = 1'b0;
    opt_run   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    w_raddr   = '0;
    w_waddr   = '0;
    w_we      = 1'b0;
    unique case (state_q)
      S_FWD: begin
        fwd_gnt = 1'b1;
        w_raddr = fwd_raddr;
      end
      S_TRANS: begin
        trans_run = 1'b1;
        busy      = 1'b1;
        w_raddr   = trans_raddr;
      end
      S_OPT: begin
        opt_run = 1'b1;
        busy    = 1'b1;
        w_raddr = opt_raddr;
        // Only the optimizer phase may write; stray opt_we elsewhere is blocked.
        w_waddr = opt_waddr;
        w_we    = opt_we;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef MIX_WEIGHT_CTRL_WATCHDOG_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // The phase counter restarts on every state change and only runs in the
  // engine phases. Expiry is qualified by the missing valid so that a valid on
  // the final cycle still completes the phase normally.
  assign wd_expire = (cnt_q == 16'(TIMEOUT - 1)) &&
                     (((state_q == S_TRANS) && !trans_valid) ||
                      ((state_q == S_OPT)   && !opt_valid));

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_TRANS) || (state_q == S_OPT)))
      cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    err_d = err_q;
    if (wd_expire)   err_d = 1'b1;
    if (enter_trans) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without the watchdog TIMEOUT has no effect.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: doc/mix_weight_ctrl.md
Name: mix_weight_ctrl

Overview:
Sequencer and access arbiter for the mix-layer weight RAM during training.
- Grants the RAM read port to the forward pass when idle.
- On a train request, runs the transpose engine over all weight words, then the optimizer update engine.
- Muxes RAM read/write addresses from whichever engine owns the RAM and pulses done at the end.
- Sits between the training top-level FSM, the transpose engine, the optimizer and the weight RAM.

Parameters:
ADDR_WIDTH, 9, weight RAM address width.
TIMEOUT, 4096, watchdog limit in cycles per phase; used only with the optional feature.

Ports:
clk  input  1  clock.
rst_n  input  1  reset.
train_start  input  1  one-cycle train-sequence request.
fwd_req  input  1  forward pass requests the RAM read port (level).
fwd_gnt  output  1  forward pass owns the read port.
fwd_raddr  input  ADDR_WIDTH  forward read address.
trans_run  output  1  transpose engine run (level; deassertion resets the engine).
trans_valid  input  1  transpose engine finished its last word.
trans_raddr  input  ADDR_WIDTH  transpose read address.
opt_run  output  1  optimizer run (level).
opt_valid  input  1  optimizer finished.
opt_raddr  input  ADDR_WIDTH  optimizer read address.
opt_waddr  input  ADDR_WIDTH  optimizer write address.
opt_we  input  1  optimizer write enable.
w_raddr  output  ADDR_WIDTH  weight RAM read address.
w_waddr  output  ADDR_WIDTH  weight RAM write address.
w_we  output  1  weight RAM write enable.
busy  output  1  train sequence in progress (TRANS, OPT).
done  output  1  one-cycle completion pulse.
err  output  1  sticky watchdog error.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset state: IDLE, pending=0, err=0.
- Under reset, all outputs are 0, including fwd_gnt, trans_run, opt_run, w_* and done.
- A reset asserted mid-sequence drops the run outputs immediately.
- FSM states: IDLE, FWD, TRANS, OPT, DONE, held in a registered state variable.
- All outputs are Moore decodes of the state plus combinational address muxes. The controller adds no RAM-path latency.
- IDLE:
  - train_start goes to TRANS. It has priority over a simultaneous fwd_req.
  - Otherwise fwd_req goes to FWD.
- FWD:
  - fwd_gnt=1.
  - train_start sets pending.
  - When fwd_req=0: go to TRANS if pending (or train_start this cycle), else IDLE. pending clears on entering TRANS.
- TRANS:
  - trans_run=1, busy=1.
  - On trans_valid=1, go to OPT; trans_run is 0 on the next cycle.
- OPT:
  - opt_run=1, busy=1.
  - On opt_valid=1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
- A train_start in TRANS/OPT/DONE is ignored (not queued).
- Read address mux for w_raddr:
  - FWD: fwd_raddr.
  - TRANS: trans_raddr.
  - OPT: opt_raddr.
  - Otherwise 0.
- Write mux:
  - In OPT: w_waddr=opt_waddr, w_we=opt_we.
  - Otherwise w_waddr=0, w_we=0, so stray opt_we writes are blocked.
- trans_valid outside TRANS and opt_valid outside OPT are ignored.
- fwd_gnt is never asserted in the same cycle as trans_run or opt_run.

Optional Feature:
MIX_WEIGHT_CTRL_WATCHDOG_EN.
- Defined:
  - A 16-bit phase counter clears on every state change and increments each cycle in TRANS and OPT.
  - When the counter reaches TIMEOUT-1 without the corresponding valid, err is set (sticky), the run outputs drop, and the FSM goes to IDLE without pulsing done.
  - err clears when a train_start is accepted into TRANS.
- Undefined: no counter; err is tied to 0.

Test Plan:
1. Reset, then train_start pulse in IDLE -> trans_run=1 next cycle. Drive trans_valid at cycle 384 -> opt_run=1 and trans_run=0 next cycle. Drive opt_valid -> done high for exactly 1 cycle, busy=0 afterwards.
2. fwd_req=1 with fwd_raddr=0x055 -> fwd_gnt=1 and w_raddr=0x055. Pulse train_start; hold fwd_req 10 more cycles -> trans_run stays 0. Drop fwd_req -> trans_run=1 on the next cycle.
3. train_start and fwd_req in the same IDLE cycle -> TRANS is entered and fwd_gnt stays 0 until after done.
4. In OPT with opt_we=1, opt_waddr=0x1A0 -> w_we=1, w_waddr=0x1A0. In TRANS with opt_we=1 -> w_we=0.
5. Assert rst_n=0 mid-TRANS -> trans_run=0 immediately. After release -> IDLE, no done pulse.
6. With MIX_WEIGHT_CTRL_WATCHDOG_EN and TIMEOUT=16, enter TRANS and never drive trans_valid -> err=1 after 16 cycles, trans_run=0, no done. Next train_start -> err=0.
